pll_lock_detect: RTL and testbench
==================================

Name: pll_lock_detect

Overview:
- Lock detector that sits directly downstream of the ring oscillator / FLL.
- Runs on the PLL output clock (clockp[0]) and measures how many output cycles fall within each period of the reference osc.
- Compares that count against the feedback ratio div and reports a qualified lock plus a sticky loss-of-lock flag to housekeeping.
- Treats osc as asynchronous data.

Parameters:
- CNT_W, 7, width of period counter and measurement output; saturates at 2^CNT_W-1
- TOL, 1, allowed |meas - div| for a window to count as good
- LOCK_CNT, 8, consecutive good windows needed to declare lock (range 1..15)
- UNLOCK_CNT, 2, consecutive bad windows needed to drop lock (range 1..15)

Ports:
- clock  input  1  PLL output clock (clockp[0])
- resetb  input  1  synchronous active-low reset, sampled on rising clock
- enable  input  1  detector enable; low forces IDLE
- osc  input  1  reference oscillator, asynchronous to clock
- div  input  5  expected clock cycles per osc period; same encoding as the PLL feedback ratio
- lost_clr  input  1  one-cycle clear for lost
- locked  output  1  lock qualified
- lost  output  1  sticky: lock was lost since last clear
- meas  output  CNT_W  last measured period, in clock cycles
- meas_valid  output  1  one-cycle pulse when meas updates

Behaviour:
- Reset (resetb==0 at clock edge): all flops clear; state=IDLE; locked=0, lost=0, meas=0, meas_valid=0.
- Synchroniser and edge detect:
  - osc passes through 2 flops, then a third delay flop.
  - osc_rise = sync2 & ~sync3.
  - An osc rising edge produces osc_rise 2-3 clocks later.
- Period counter pcnt:
  - On osc_rise: pcnt<=1.
  - Otherwise: pcnt<=pcnt+1, saturating at max.
- Measurement:
  - Taken on osc_rise in states ACQ/LOCKED: meas<=pcnt; meas_valid pulses the following cycle, aligned with meas.
  - No meas_valid in IDLE or ARM.
- Window classification:
  - good = (pcnt != max) && (div != 0) && |pcnt - div| <= TOL.
  - Compute the difference in CNT_W+1 bits, with div zero-extended.
- div tracking: div is registered each cycle. A change in div while in ACQ/LOCKED forces ARM next cycle; locked falls on that same edge; lost is not set.
- States:
  - IDLE: counters held at 0. Go to ARM when enable=1.
  - ARM: wait for the first osc_rise; that edge only restarts pcnt (no measurement). Go to ACQ.
  - ACQ:
    - Each osc_rise: if good, gcnt++ else gcnt<=0.
    - When gcnt reaches LOCK_CNT, go to LOCKED; locked=1 registered in the same edge as the transition.
  - LOCKED:
    - Each osc_rise: if bad, bcnt++ else bcnt<=0.
    - When bcnt reaches UNLOCK_CNT, go to ACQ, locked<=0, lost<=1, gcnt<=0.
  - Saturation timeout: pcnt reaching max in LOCKED (osc stopped) is immediately treated as loss, with the same effect as a bad-window unlock. In ACQ, saturation resets gcnt.
- enable low in any state: next state IDLE, locked<=0. lost is retained.
- lost_clr clears lost. If set and clear occur in the same cycle, set wins.
- Reset mid-operation overrides everything, including a pending lock or loss.

Test Plan:
- Lock acquire:
  - Stimulus: div=8, osc period 8 clocks, enable=1, TOL=1, LOCK_CNT=8.
  - Required: meas=8 with meas_valid per window; first osc_rise produces no meas; locked rises on the edge of the 9th osc_rise; lost=0.
- Tolerance edge:
  - Stimulus: div=10, osc periods alternating 9/11.
  - Required: locks after 8 windows.
  - Then a period of 12 resets gcnt (locked stays 0 if not yet locked).
- Loss of lock:
  - Stimulus: after lock, 2 consecutive periods of 16 with div=8.
  - Required: locked falls at the 2nd bad osc_rise; lost=1; state ACQ.
  - Then lost_clr pulse: lost=0.
  - Repeat with a single bad window: locked stays 1.
- Osc stop:
  - Stimulus: locked, then osc held low.
  - Required: locked falls the cycle pcnt reaches 127; lost=1.
  - Same cycle as lost_clr: lost stays 1.
- div change / enable:
  - Stimulus: locked with div=8, then div=9.
  - Required: locked=0 the next cycle, lost=0, re-acquires on matching osc.
  - enable=0: locked=0 and lost is held.
  - div=0: never locks.
- Reset mid-run:
  - Stimulus: resetb=0 for one clock while locked and lost=1.
  - Required: all outputs 0 after that edge; resuming shows no meas_valid until the 2nd osc_rise.

Source files
------------

// File: rtl/pll_lock_detect.sv
// rtl/pll_lock_detect.sv - PLL lock detector measuring clock cycles per reference osc period
module pll_lock_detect #(
    parameter int CNT_W      = 7,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [4:0]       div,
    input  logic             lost_clr,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACQ    = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PCNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_V = 4'(UNLOCK_CNT);

    state_t           state;
    logic             sync1, sync2, sync3;
    logic             osc_rise;
    logic [CNT_W-1:0] pcnt;
    logic [4:0]       div_q;
    logic [3:0]       gcnt, bcnt;
    logic [CNT_W:0]   diff, abs_diff;
    logic             sat, good, tracking, div_chg, loss;

    assign osc_rise = sync2 & ~sync3;
    assign sat      = (pcnt == PCNT_MAX);

    // Signed distance between the measured period and the expected ratio, one bit wider than the counter.
    assign diff     = {1'b0, pcnt} - {{(CNT_W-4){1'b0}}, div_q};
    assign abs_diff = diff[CNT_W] ? (~diff + 1'b1) : diff;
    assign good     = !sat && (div_q != 5'd0) && (abs_diff <= TOL_V);

    assign tracking = (state == ACQ) || (state == LOCKED);
    assign div_chg  = tracking && (div != div_q);

    // Loss happens in LOCKED on the final bad window, or immediately when the period counter saturates.
    assign loss = (state == LOCKED) && enable && !div_chg &&
                  (osc_rise ? (!good && (bcnt == UNLOCK_V - 4'd1)) : sat);

    // Two-flop synchroniser for the asynchronous osc, plus a delay flop for rising-edge detection.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= osc;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Period counter: restarts at 1 on each osc edge, saturates so a stopped osc is visible.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            pcnt <= '0;
        end else if (state == IDLE) begin
            pcnt <= '0;
        end else if (osc_rise) begin
            pcnt <= CNT_W'(1);
        end else if (!sat) begin
            pcnt <= pcnt + CNT_W'(1);
        end
    end

    // Register the feedback ratio so a change can be detected against the previous cycle.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            div_q <= 5'd0;
        end else begin
            div_q <= div;
        end
    end

    // Capture the completed period on each tracked osc edge, with a one-cycle valid pulse.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            meas       <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= osc_rise && tracking;
            if (osc_rise && tracking) begin
                meas <= pcnt;
            end
        end
    end

    // Lock qualification state machine with registered locked/lost outputs.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state  <= IDLE;
            locked <= 1'b0;
            lost   <= 1'b0;
            gcnt   <= 4'd0;
            bcnt   <= 4'd0;
        end else begin
            if (loss) begin
                lost <= 1'b1;
            end else if (lost_clr) begin
                lost <= 1'b0;
            end

            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
                gcnt   <= 4'd0;
                bcnt   <= 4'd0;
            end else if (div_chg) begin
                state  <= ARM;
                locked <= 1'b0;
                gcnt   <= 4'd0;
                bcnt   <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM: begin
                        if (osc_rise) begin
                            state <= ACQ;
                            gcnt  <= 4'd0;
                        end
                    end
                    ACQ: begin
                        if (osc_rise) begin
                            if (good) begin
                                gcnt <= gcnt + 4'd1;
                                if (gcnt == LOCK_V - 4'd1) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    bcnt   <= 4'd0;
                                end
                            end else begin
                                gcnt <= 4'd0;
                            end
                        end else if (sat) begin
                            gcnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (loss) begin
                            state  <= ACQ;
                            locked <= 1'b0;
                            gcnt   <= 4'd0;
                            bcnt   <= 4'd0;
                        end else if (osc_rise) begin
                            bcnt <= good ? 4'd0 : bcnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_detect.sv
// tb/tb_pll_lock_detect.sv - self-checking bench for pll_lock_detect against a timestamp-based reference model
module tb_pll_lock_detect;

    localparam int CNT_W      = 7;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 2;
    localparam int PMAX       = 127;

    localparam int S_IDLE   = 0;
    localparam int S_ARM    = 1;
    localparam int S_ACQ    = 2;
    localparam int S_LOCKED = 3;

    logic             clock    = 1'b0;
    logic             resetb   = 1'b0;
    logic             enable   = 1'b0;
    logic             osc      = 1'b0;
    logic [4:0]       div      = 5'd0;
    logic             lost_clr = 1'b0;
    logic             locked, lost, meas_valid;
    logic [CNT_W-1:0] meas;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation bookkeeping
    int mv_seen      = 0;
    int mv_at_lock   = -1;
    int lost_at_fall = -1;
    bit locked_prev  = 1'b0;

    // Reference model state
    int ms = S_IDLE;
    int good_run = 0, bad_run = 0, div_prev = 0;
    int edge_no = 0, anc_edge = 0, anc_val = 0;
    bit h0 = 0, h1 = 0, h2 = 0;
    bit m_locked = 0, m_lost = 0, m_mv = 0;
    int m_meas = 0;

    pll_lock_detect #(
        .CNT_W(CNT_W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .osc(osc), .div(div),
        .lost_clr(lost_clr), .locked(locked), .lost(lost), .meas(meas), .meas_valid(meas_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: osc edges are seen two clocks after being sampled; the period count is derived
    // from the edge timestamp of the last restart rather than from a counter.
    task automatic model_step();
        int pc;
        bit rise, good, trk, dchg, loss;
        edge_no++;
        if (!resetb) begin
            ms = S_IDLE; good_run = 0; bad_run = 0; div_prev = 0;
            anc_edge = edge_no; anc_val = 0;
            h0 = 0; h1 = 0; h2 = 0;
            m_locked = 0; m_lost = 0; m_mv = 0; m_meas = 0;
            return;
        end
        rise = h1 && !h2;
        pc = anc_val + (edge_no - 1 - anc_edge);
        if (pc > PMAX) pc = PMAX;
        good = (pc != PMAX) && (div_prev != 0) && (pc - div_prev <= TOL) && (div_prev - pc <= TOL);
        trk  = (ms == S_ACQ) || (ms == S_LOCKED);
        dchg = trk && (int'(div) != div_prev);
        m_mv = rise && trk;
        if (m_mv) m_meas = pc;
        if (ms == S_IDLE) begin
            anc_edge = edge_no; anc_val = 0;
        end else if (rise) begin
            anc_edge = edge_no; anc_val = 1;
        end
        loss = 0;
        if (!enable) begin
            ms = S_IDLE; m_locked = 0; good_run = 0; bad_run = 0;
        end else if (dchg) begin
            ms = S_ARM; m_locked = 0; good_run = 0; bad_run = 0;
        end else if (ms == S_IDLE) begin
            ms = S_ARM;
        end else if (ms == S_ARM) begin
            if (rise) begin
                ms = S_ACQ; good_run = 0;
            end
        end else if (ms == S_ACQ) begin
            if (rise && good) begin
                good_run++;
                if (good_run == LOCK_CNT) begin
                    ms = S_LOCKED; m_locked = 1; bad_run = 0;
                end
            end else if (rise || pc == PMAX) begin
                good_run = 0;
            end
        end else begin
            if (rise) begin
                if (good) bad_run = 0;
                else begin
                    bad_run++;
                    if (bad_run == UNLOCK_CNT) loss = 1;
                end
            end else if (pc == PMAX) begin
                loss = 1;
            end
            if (loss) begin
                ms = S_ACQ; m_locked = 0; good_run = 0; bad_run = 0;
            end
        end
        if (loss) m_lost = 1;
        else if (lost_clr) m_lost = 0;
        div_prev = int'(div);
        h2 = h1; h1 = h0; h0 = osc;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("locked", locked, m_locked);
        check("lost", lost, m_lost);
        check("meas_valid", meas_valid, m_mv);
        check("meas", meas, m_meas);
        if (meas_valid) mv_seen++;
        if (locked && !locked_prev) mv_at_lock = mv_seen;
        if (!locked && locked_prev) lost_at_fall = lost;
        locked_prev = locked;
    endtask

    task automatic osc_period(input int p);
        for (int i = 0; i < p; i++) begin
            osc = (i < (p + 1) / 2);
            tick();
        end
    endtask

    task automatic periods(input int p, input int n);
        for (int k = 0; k < n; k++) osc_period(p);
    endtask

    initial begin
        // Reset state
        resetb = 1'b0;
        repeat (3) tick();
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        check("rst_meas", meas, 0);
        check("rst_meas_valid", meas_valid, 0);
        resetb = 1'b1;

        // Lock acquire at div=8
        div = 5'd8; enable = 1'b1;
        tick();
        mv_seen = 0; mv_at_lock = -1;
        periods(8, 12);
        check("acq_windows_before_lock", mv_at_lock, LOCK_CNT);
        check("acq_locked", locked, 1);
        check("acq_meas", meas, 8);
        check("acq_lost", lost, 0);

        // Single bad window keeps lock
        osc_period(16);
        periods(8, 6);
        check("one_bad_locked", locked, 1);
        check("one_bad_lost", lost, 0);

        // Two consecutive bad windows drop lock
        periods(16, 2);
        osc_period(8);
        check("loss_locked", locked, 0);
        check("loss_lost", lost, 1);

        // Re-lock, then enable low drops lock and keeps lost
        periods(8, 10);
        check("relock_locked", locked, 1);
        enable = 1'b0;
        tick();
        check("en_low_locked", locked, 0);
        check("en_low_lost_held", lost, 1);
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        tick();
        check("lost_clr", lost, 0);

        // Tolerance edge at div=10 with 9/11 alternation; a 12 restarts qualification
        div = 5'd10; enable = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin osc_period(9); osc_period(11); end
        osc_period(12);
        osc_period(9); osc_period(11); osc_period(9); osc_period(11);
        check("tol_after_12_unlocked", locked, 0);
        for (int k = 0; k < 3; k++) begin osc_period(9); osc_period(11); end
        check("tol_locked", locked, 1);

        // Osc stop with lost_clr held: set must win on the timeout edge
        lost_at_fall = -1;
        osc = 1'b0; lost_clr = 1'b1;
        repeat (150) tick();
        lost_clr = 1'b0;
        check("stop_lost_on_fall", lost_at_fall, 1);
        check("stop_locked", locked, 0);

        // div change while locked
        div = 5'd8;
        periods(8, 11);
        check("div8_locked", locked, 1);
        div = 5'd9;
        tick();
        check("divchg_locked", locked, 0);
        check("divchg_lost", lost, 0);
        periods(9, 11);
        check("div9_relocked", locked, 1);

        // Reset while locked with lost set
        periods(16, 2);
        osc_period(9);
        periods(9, 10);
        check("pre_rst_locked", locked, 1);
        check("pre_rst_lost", lost, 1);
        resetb = 1'b0;
        tick();
        check("midrst_locked", locked, 0);
        check("midrst_lost", lost, 0);
        check("midrst_meas", meas, 0);
        check("midrst_meas_valid", meas_valid, 0);
        resetb = 1'b1;
        mv_seen = 0;
        periods(9, 3);
        check("rst_resume_mv_count", mv_seen, 2);

        // div=0 never locks
        div = 5'd0;
        for (int k = 0; k < 20; k++) osc_period($urandom_range(2, 12));
        check("div0_unlocked", locked, 0);

        // Randomized operation against the model
        for (int k = 0; k < 220; k++) begin
            int p;
            if ($urandom_range(0, 14) == 0) div = 5'($urandom_range(0, 25));
            if ($urandom_range(0, 59) == 0) begin
                resetb = 1'b0; tick(); resetb = 1'b1;
            end
            enable   = ($urandom_range(0, 19) != 0);
            lost_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) p = $urandom_range(2, 140);
            else p = int'(div) + int'($urandom_range(0, 4)) - 2;
            if (p < 2) p = 2;
            osc_period(p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
